puf_scan_host: RTL and testbench

- Host-side scan master for the PUF super block: drives its scan input (si) and collects its scan output (so).
- Takes a challenge word over a valid/ready command port and shifts it serially into the PUF scan chain with PUF select and length configuration held stable.
- Waits a programmable evaluation window, pulses capture, then shifts the response chain out and presents it as a parallel word over a valid/ready response port.

---
 rtl/puf_scan_host.sv | 149 ++++++++++++++
 tb/tb_puf_scan_host.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_scan_host.sv
// Host-side scan master for the PUF super block.
// Loads a challenge serially, pulses capture, unloads the response word.
module puf_scan_host #(
  parameter int CHAIN_LEN    = 48,
  parameter int CAPTURE_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CHAIN_LEN-1:0] cmd_challenge,
  input  logic [1:0]           cmd_puf_sel,
  input  logic [1:0]           cmd_length,
  output logic [1:0]           puf_sel,
  output logic [1:0]           length,
  output logic                 si,
  input  logic                 so,
  output logic                 scan_en,
  output logic                 capture,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 busy
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = (CAPTURE_WAIT > 1) ? $clog2(CAPTURE_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  localparam logic [WW-1:0] WLAST =
    WW'((CAPTURE_WAIT > 0) ? CAPTURE_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAP,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CHAIN_LEN-1:0] sr;
  logic [CW-1:0]        cnt;
  logic [WW-1:0]        wcnt;
  logic                 bit_last;
  logic                 wait_last;

  assign bit_last  = (cnt == LAST);
  assign wait_last = (wcnt == WLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    scan_en    = 1'b0;
    capture    = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nx = S_LOAD;
      end
      S_LOAD: begin
        scan_en = 1'b1;
        if (bit_last) begin
          if (CAPTURE_WAIT == 0) state_nx = S_CAP;
          else                   state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_last) state_nx = S_CAP;
      end
      S_CAP: begin
        capture  = 1'b1;
        state_nx = S_UNLOAD;
      end
      S_UNLOAD: begin
        scan_en = 1'b1;
        if (bit_last) state_nx = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters restart on every state change so each phase counts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      wcnt <= '0;
    end else if (state_nx != state) begin
      cnt  <= '0;
      wcnt <= '0;
    end else begin
      if (scan_en)          cnt  <= cnt + CW'(1);
      if (state == S_WAIT)  wcnt <= wcnt + WW'(1);
    end
  end

  // One shift register serves both directions: drained during LOAD,
  // then refilled from so during UNLOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      si        <= 1'b0;
      resp_data <= '0;
      puf_sel   <= 2'd0;
      length    <= 2'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sr      <= cmd_challenge >> 1;
            si      <= cmd_challenge[0];
            puf_sel <= cmd_puf_sel;
            length  <= cmd_length;
          end
        end
        S_LOAD: begin
          if (bit_last) begin
            si <= 1'b0;
          end else begin
            si <= sr[0];
            sr <= sr >> 1;
          end
        end
        S_UNLOAD: begin
          sr <= {so, sr[CHAIN_LEN-1:1]};
          if (bit_last) resp_data <= {so, sr[CHAIN_LEN-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_scan_host.sv
// Scoreboard bench for puf_scan_host: default build plus a
// CHAIN_LEN=2 / CAPTURE_WAIT=0 build, both with a scan chain model.
module tb_puf_scan_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [47:0] cmd_challenge = '0;
  logic [1:0]  cmd_puf_sel = '0;
  logic [1:0]  cmd_length = '0;
  logic [1:0]  puf_sel;
  logic [1:0]  length;
  logic        si;
  logic        so;
  logic        scan_en;
  logic        capture;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [47:0] resp_data;
  logic        busy;

  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [1:0]  s_ch = '0;
  logic [1:0]  s_puf_sel;
  logic [1:0]  s_length;
  logic        s_si;
  logic        s_so;
  logic        s_scan_en;
  logic        s_capture;
  logic        s_resp_valid;
  logic [1:0]  s_resp_data;
  logic        s_busy;

  always #5 clk = ~clk;

  puf_scan_host u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_challenge(cmd_challenge),
    .cmd_puf_sel(cmd_puf_sel), .cmd_length(cmd_length),
    .puf_sel(puf_sel), .length(length),
    .si(si), .so(so), .scan_en(scan_en), .capture(capture),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy)
  );

  puf_scan_host #(.CHAIN_LEN(2), .CAPTURE_WAIT(0)) u_small (
    .clk(clk), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_challenge(s_ch),
    .cmd_puf_sel(2'd1), .cmd_length(2'd2),
    .puf_sel(s_puf_sel), .length(s_length),
    .si(s_si), .so(s_so), .scan_en(s_scan_en), .capture(s_capture),
    .resp_valid(s_resp_valid), .resp_ready(1'b1),
    .resp_data(s_resp_data), .busy(s_busy)
  );

  // scan chain models and so source selection
  logic [47:0] chain;
  logic [1:0]  s_chain;
  logic [7:0]  ucnt;
  int          so_mode = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      chain   <= '0;
      s_chain <= '0;
    end else begin
      if (scan_en)   chain   <= {chain[46:0], si};
      if (s_scan_en) s_chain <= {s_chain[0], s_si};
    end
  end

  always @(posedge clk) begin
    if (capture)      ucnt <= '0;
    else if (scan_en) ucnt <= ucnt + 8'd1;
  end

  assign so   = (so_mode == 0) ? chain[47] :
                (so_mode == 1) ? 1'b1 : ucnt[0];
  assign s_so = s_chain[1];

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [47:0] data;
    longint      acc;
  } exp_t;

  exp_t sb[$];

  // monitor: every new response is matched against the scoreboard
  logic   prev_v = 1'b0;
  int     vseen = 0;
  int     cap_n = 0;
  longint cap_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (capture) begin
      cap_n++;
      cap_cyc = cyc;
    end
    if (resp_valid) vseen++;
    if (resp_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got %0h expected none", resp_data);
      end else begin
        e = sb.pop_front();
        chk("resp_data", {16'd0, resp_data}, {16'd0, e.data});
        chk("latency", cyc - e.acc, 64'd101);
      end
    end
    prev_v = resp_valid;
  end

  // call at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [47:0] ch, input logic [1:0] sel,
                      input logic [1:0] len, input logic [47:0] exp,
                      input bit want, output longint acc);
    int n;
    exp_t e;
    cmd_challenge = ch;
    cmd_puf_sel   = sel;
    cmd_length    = len;
    cmd_valid     = 1'b1;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got none expected accept");
    end
    acc = cyc + 1;
    if (want) begin
      e.data = exp;
      e.acc  = acc;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got none expected resp");
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [47:0] ch;
    longint      a0, a1, a2, r_edge;
    int          c0, n, s_cap, s_lat;
    logic [1:0]  s_dat;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle",
          {54'd0, cmd_ready, busy, si, scan_en, capture, resp_valid,
           puf_sel, length},
          64'b10_0000_0000);
      if (i == 0) chk("reset_resp_data", {16'd0, resp_data}, 64'd0);
    end

    // loopback challenge with per-cycle si check
    so_mode = 0;
    ch = 48'hA5A5_0F0F_1234;
    c0 = cap_n;
    send(ch, 2'd2, 2'd3, ch, 1'b1, a0);
    chk("sel_len_latched", {60'd0, puf_sel, length}, 64'hB);
    for (int k = 0; k < 48; k++) begin
      chk("si_load", {62'd0, scan_en, si}, {62'd0, 1'b1, ch[k]});
      @(negedge clk);
    end
    drain();
    chk("capture_count", cap_n - c0, 64'd1);
    chk("capture_time", cap_cyc - a0, 64'd52);
    chk("sel_len_held", {60'd0, busy, puf_sel, length}, 64'hB);

    so_mode = 1;
    send(48'h0123_4567_89AB, 2'd1, 2'd1, 48'hFFFF_FFFF_FFFF, 1'b1, a0);
    drain();

    so_mode = 2;
    send(48'h0, 2'd0, 2'd2, 48'hAAAA_AAAA_AAAA, 1'b1, a0);
    drain();

    // response stall with a competing command
    so_mode = 0;
    resp_ready = 1'b0;
    send(48'h5A5A_C3C3_7E7E, 2'd3, 2'd0, 48'h5A5A_C3C3_7E7E, 1'b1, a0);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", {63'd0, resp_valid}, 64'd1);
    cmd_challenge = 48'h1111_2222_3333;
    cmd_valid     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold",
          {13'd0, resp_valid, cmd_ready, resp_data},
          {13'd0, 1'b1, 1'b0, 48'h5A5A_C3C3_7E7E});
      @(negedge clk);
    end
    resp_ready = 1'b1;
    r_edge = cyc + 1;
    send(48'h1111_2222_3333, 2'd1, 2'd2, 48'h1111_2222_3333, 1'b1, a0);
    chk("accept_after_ready", a0 - r_edge, 64'd1);
    // 102 busy cycles, then the accepting IDLE cycle
    send(48'hDEAD_BEEF_0001, 2'd2, 2'd1, 48'hDEAD_BEEF_0001, 1'b1, a1);
    chk("b2b_period_1", a1 - a0, 64'd103);
    send(48'h8000_0000_0001, 2'd0, 2'd3, 48'h8000_0000_0001, 1'b1, a2);
    chk("b2b_period_2", a2 - a1, 64'd103);
    drain();

    // abort during UNLOAD bit 20
    send(48'hFEDC_BA98_7654, 2'd3, 2'd3, 48'h0, 1'b0, a0);
    n = 0;
    while (cyc != a0 + 73 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_unload", {63'd0, scan_en}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_async",
        {6'd0, cmd_ready, busy, si, scan_en, capture, resp_valid,
         puf_sel, length, resp_data},
        {6'd0, 10'b10_0000_0000, 48'd0});
    @(negedge clk);
    reset = 1'b0;
    vseen = 0;
    repeat (150) @(negedge clk);
    chk("no_resp_after_abort", vseen, 64'd0);
    send(48'h0F0F_F0F0_55AA, 2'd1, 2'd0, 48'h0F0F_F0F0_55AA, 1'b1, a0);
    drain();

    // small build
    s_ch = 2'b10;
    s_cmd_valid = 1'b1;
    chk("small_ready", {63'd0, s_cmd_ready}, 64'd1);
    a0 = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    s_cmd_valid = 1'b0;
    s_cap = -1;
    s_lat = -1;
    s_dat = '0;
    for (int i = 0; i < 20; i++) begin
      if (s_capture && s_cap < 0) s_cap = int'(cyc - a0);
      if (s_resp_valid && s_lat < 0) begin
        s_lat = int'(cyc - a0);
        s_dat = s_resp_data;
      end
      @(negedge clk);
    end
    chk("small_capture_time", s_cap, 64'd2);
    chk("small_latency", s_lat, 64'd5);
    chk("small_loopback", {62'd0, s_dat}, 64'd2);
    chk("small_sel_len", {60'd0, s_puf_sel, s_length}, 64'h6);

    chk("sb_empty", sb.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
